alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the Execute-stage ALU. Accepts one op per
//  cycle over a valid/ready handshake and registers its result and condition codes.
//  Adds carry-chained ADC/SBB, shifts and an iterative multiplier.
//  Sits between decode/operand fetch and the writeback stage.
// PARAMETERS
//  WIDTH   32  operand/result width, >=4, power of two
//  MUL_EN  1   1: MUL implemented; 0: MUL behaves as NOP
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  i_valid     in   1      op/operands valid
//  o_ready     out  1      block accepts op this cycle
//  i_ALU_Ctrl  in   4      operation code
//  i_Op1       in   WIDTH  operand 1
//  i_Op2       in   WIDTH  operand 2 (shift amount = low log2(WIDTH) bits)
//  i_CC_WE     in   1      update condition codes when this op completes
//  o_valid     out  1      result valid
//  i_ready     in   1      downstream accepts result
//  o_rslt      out  WIDTH  registered result
//  o_CCodes    out  4      {V,C,N,Z} = bits [3:0] = {OVERFLOW,CARRY,NEGATIVE,ZERO}
// BEHAVIOUR
//  Reset: o_valid=0, o_rslt=0, o_CCodes=0, FSM=IDLE, MUL counter/accumulator=0.
//  Reset mid-MUL aborts the op; no result is produced.
//  Accept: i_valid & o_ready at a rising edge. o_ready = (state==IDLE) & (~o_valid | i_ready).
//  Output register holds o_rslt/o_valid until o_valid & i_ready.
//  Retire and accept in the same cycle is legal (full throughput).
//  Opcodes:
//   0000 NOP, 0001 ADD, 0010 SUB, 0011 OR, 0100 AND, 0101 NOT(Op1), 0110 XOR,
//   0111 ADC (Op1+Op2+C), 1000 SBB (Op1-Op2-C), 1001 SHL, 1010 SHR, 1011 SRA,
//   1100 MUL (low WIDTH bits of unsigned product).
//   Unlisted codes (and MUL when MUL_EN=0) behave as NOP: result 0.
//  Latency:
//   - Single-cycle ops: accepted at edge N, o_valid=1 after edge N (1 cycle).
//   - MUL: FSM IDLE->MUL at accept, one shift-add step per cycle for WIDTH cycles,
//     MUL->IDLE with o_valid=1 after edge N+WIDTH. o_ready=0 while in MUL.
//  Arithmetic: computed on WIDTH+1 bits; bit WIDTH = carry out.
//   - For SUB/SBB, carry = borrow (1 when Op1 < Op2 + Cin, unsigned).
//   - ADC/SBB carry-in C is o_CCodes[2] as registered at the accept edge; it includes
//     a CC update retiring at that same edge only if that update was registered earlier.
//     Back-to-back ADC after ADD therefore sees the ADD carry.
//  Condition codes are written at the edge the result enters the output register,
//  only if i_CC_WE was 1 at accept (captured with the op):
//   - Z = (rslt==0); N = rslt[WIDTH-1].
//   - C: ADD/ADC/SUB/SBB: carry/borrow. SHL/SHR/SRA: last bit shifted out (0 if amount=0).
//     MUL: 1 if upper WIDTH bits of the full product are nonzero. Others: 0.
//   - V: ADD/ADC/SUB/SBB: signed overflow (operand signs, Op2 sign inverted for subtract,
//     match and differ from result sign). MUL: V=C. Others: 0.
//   - i_CC_WE=0: o_CCodes unchanged. NOP with CC_WE=1: Z=1, N=C=V=0.
//  Shifts: amount = Op2[log2(WIDTH)-1:0]; SRA replicates bit WIDTH-1.
//  i_valid while o_ready=0: op is ignored, not queued; the upstream must hold it.
// TESTING
//  - ADD 0xFFFFFFFF+1, CC_WE=1 -> o_rslt=0, Z=1, C=1, N=0, V=0, one cycle after accept.
//  - ADD 0xFFFFFFFF+1 then back-to-back ADC 0+0 -> ADC rslt=1, C=0, Z=0.
//    Then SUB 3-5 -> 0xFFFFFFFE, N=1, C=1.
//  - ADD 0x7FFFFFFF+1 -> V=1, N=1.
//    SRA 0x80000000 by 4 -> 0xF8000000.
//    SHL 0x80000001 by 1 -> 0x00000002, C=1.
//  - MUL 0x10000*0x10000 -> o_rslt=0, C=V=1, o_valid exactly WIDTH+1 cycles after accept.
//    o_ready low throughout the MUL.
//  - Hold i_ready=0 with two queued ops -> second not accepted, o_rslt stable.
//    Release -> both retire in order, one per cycle.
//  - Assert reset during MUL cycle 10 -> o_valid=0, o_CCodes=0, o_ready=1 after release.
//    Next ADD completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake, carry-chained ADC/SBB,
// shifts and a WIDTH-cycle shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_ALU_Ctrl,
    input  logic [WIDTH-1:0] i_Op1,
    input  logic [WIDTH-1:0] i_Op2,
    input  logic             i_CC_WE,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_rslt,
    output logic [3:0]       o_CCodes
);

    localparam int LG = $clog2(WIDTH);
    localparam int unsigned CNT_LAST_I = WIDTH - 1;
    localparam logic [LG:0] CNT_LAST = CNT_LAST_I[LG:0];

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_ADC = 4'b0111;
    localparam logic [3:0] OP_SBB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    // Signed overflow: effective operand signs agree but the result sign differs.
    function automatic logic f_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

    logic [0:0]         r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [LG:0]        r_cnt;
    logic               r_cc_we;

    logic                    w_accept;
    logic                    w_is_mul;
    logic                    w_cin;
    logic                    w_mul_done;
    logic                    w_mul_c;
    logic [LG-1:0]           w_amt;
    logic [WIDTH:0]          w_ext;
    logic [WIDTH:0]          w_shl_ext;
    logic [WIDTH:0]          w_shr_ext;
    logic signed [WIDTH:0]   w_sra_ext;
    logic [WIDTH:0]          w_mul_add;
    logic [2*WIDTH-1:0]      w_acc_next;
    logic [WIDTH-1:0]        w_rslt;
    logic                    w_c;
    logic                    w_v;

    assign o_ready  = (r_state == S_IDLE) && (!o_valid || i_ready);
    assign w_accept = i_valid && o_ready;
    assign w_is_mul = MUL_EN && (i_ALU_Ctrl == OP_MUL);
    assign w_cin    = o_CCodes[2];
    assign w_amt    = i_Op2[LG-1:0];

    // Shifts carry one guard bit so the last bit shifted out lands in it (0 when amount is 0).
    assign w_shl_ext = {1'b0, i_Op1} << w_amt;
    assign w_shr_ext = {i_Op1, 1'b0} >> w_amt;
    assign w_sra_ext = $signed({i_Op1, 1'b0}) >>> w_amt;

    assign w_mul_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_mul_add, r_acc[WIDTH-1:1]};
    assign w_mul_c    = |w_acc_next[2*WIDTH-1:WIDTH];
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);

    // Single-cycle result and C/V flags for the op being presented.
    always_comb begin
        w_ext  = {(WIDTH+1){1'b0}};
        w_rslt = {WIDTH{1'b0}};
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (i_ALU_Ctrl)
            OP_ADD, OP_ADC: begin
                w_ext  = {1'b0, i_Op1} + {1'b0, i_Op2}
                       + {{WIDTH{1'b0}}, (i_ALU_Ctrl == OP_ADC) && w_cin};
                w_rslt = w_ext[WIDTH-1:0];
                w_c    = w_ext[WIDTH];
                w_v    = f_ovf(i_Op1[WIDTH-1], i_Op2[WIDTH-1], w_ext[WIDTH-1], 1'b0);
            end
            OP_SUB, OP_SBB: begin
                w_ext  = {1'b0, i_Op1} - {1'b0, i_Op2}
                       - {{WIDTH{1'b0}}, (i_ALU_Ctrl == OP_SBB) && w_cin};
                w_rslt = w_ext[WIDTH-1:0];
                w_c    = w_ext[WIDTH];
                w_v    = f_ovf(i_Op1[WIDTH-1], i_Op2[WIDTH-1], w_ext[WIDTH-1], 1'b1);
            end
            OP_OR:  w_rslt = i_Op1 | i_Op2;
            OP_AND: w_rslt = i_Op1 & i_Op2;
            OP_NOT: w_rslt = ~i_Op1;
            OP_XOR: w_rslt = i_Op1 ^ i_Op2;
            OP_SHL: begin
                w_rslt = w_shl_ext[WIDTH-1:0];
                w_c    = w_shl_ext[WIDTH];
            end
            OP_SHR: begin
                w_rslt = w_shr_ext[WIDTH:1];
                w_c    = w_shr_ext[0];
            end
            OP_SRA: begin
                w_rslt = w_sra_ext[WIDTH:1];
                w_c    = w_sra_ext[0];
            end
            default: w_rslt = {WIDTH{1'b0}};
        endcase
    end

    // FSM and multiplier: accumulator starts as {0, Op2} and shifts right once per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= {(2*WIDTH){1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_cnt   <= {(LG+1){1'b0}};
            r_cc_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state <= S_MUL;
                        r_acc   <= {{WIDTH{1'b0}}, i_Op2};
                        r_mcand <= i_Op1;
                        r_cnt   <= {(LG+1){1'b0}};
                        r_cc_we <= i_CC_WE;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + {{LG{1'b0}}, 1'b1};
                    if (w_mul_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register and condition codes; loads from the multiplier or a single-cycle op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid  <= 1'b0;
            o_rslt   <= {WIDTH{1'b0}};
            o_CCodes <= 4'b0000;
        end else if (w_mul_done) begin
            o_valid <= 1'b1;
            o_rslt  <= w_acc_next[WIDTH-1:0];
            if (r_cc_we) begin
                o_CCodes <= {w_mul_c, w_mul_c, w_acc_next[WIDTH-1],
                             w_acc_next[WIDTH-1:0] == {WIDTH{1'b0}}};
            end
        end else if (w_accept && !w_is_mul) begin
            o_valid <= 1'b1;
            o_rslt  <= w_rslt;
            if (i_CC_WE) begin
                o_CCodes <= {w_v, w_c, w_rslt[WIDTH-1], w_rslt == {WIDTH{1'b0}}};
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32, MUL_EN=1).
module tb_alu_pipe;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_ALU_Ctrl;
    logic [31:0] i_Op1;
    logic [31:0] i_Op2;
    logic        i_CC_WE;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rslt;
    logic [3:0]  o_CCodes;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALU_Ctrl(i_ALU_Ctrl), .i_Op1(i_Op1), .i_Op2(i_Op2), .i_CC_WE(i_CC_WE),
        .o_valid(o_valid), .i_ready(i_ready), .o_rslt(o_rslt), .o_CCodes(o_CCodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic we);
        i_ALU_Ctrl = op; i_Op1 = a; i_Op2 = b; i_CC_WE = we; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_ALU_Ctrl = 4'b0000; i_Op1 = 32'h0; i_Op2 = 32'h0; i_CC_WE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp %b", o_valid, 1'b0); end
        n_checks++; if (o_rslt !== 32'h0) begin n_fail++; $display("FAIL reset_rslt: got %h exp %h", o_rslt, 32'h0); end
        n_checks++; if (o_CCodes !== 4'b0000) begin n_fail++; $display("FAIL reset_cc: got %b exp %b", o_CCodes, 4'b0000); end
        reset = 1'b0;
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp %b", o_ready, 1'b1); end
    endtask

    task automatic test_back_to_back();
        send(4'b0001, 32'hFFFF_FFFF, 32'h1, 1'b1);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL add_wrap_valid: got %b exp %b", o_valid, 1'b1); end
        n_checks++; if (o_rslt !== 32'h0) begin n_fail++; $display("FAIL add_wrap_rslt: got %h exp %h", o_rslt, 32'h0); end
        n_checks++; if (o_CCodes !== 4'b0101) begin n_fail++; $display("FAIL add_wrap_cc: got %b exp %b", o_CCodes, 4'b0101); end
        send(4'b0111, 32'h0, 32'h0, 1'b1);
        n_checks++; if (o_rslt !== 32'h1) begin n_fail++; $display("FAIL adc_rslt: got %h exp %h", o_rslt, 32'h1); end
        n_checks++; if (o_CCodes !== 4'b0000) begin n_fail++; $display("FAIL adc_cc: got %b exp %b", o_CCodes, 4'b0000); end
        send(4'b0010, 32'h3, 32'h5, 1'b1);
        n_checks++; if (o_rslt !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_rslt: got %h exp %h", o_rslt, 32'hFFFF_FFFE); end
        n_checks++; if (o_CCodes !== 4'b0110) begin n_fail++; $display("FAIL sub_cc: got %b exp %b", o_CCodes, 4'b0110); end
    endtask

    task automatic test_flags_shifts();
        send(4'b0001, 32'h7FFF_FFFF, 32'h1, 1'b1);
        n_checks++; if (o_rslt !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_rslt: got %h exp %h", o_rslt, 32'h8000_0000); end
        n_checks++; if (o_CCodes !== 4'b1010) begin n_fail++; $display("FAIL ovf_cc: got %b exp %b", o_CCodes, 4'b1010); end
        send(4'b1011, 32'h8000_0000, 32'h4, 1'b1);
        n_checks++; if (o_rslt !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_rslt: got %h exp %h", o_rslt, 32'hF800_0000); end
        n_checks++; if (o_CCodes !== 4'b0010) begin n_fail++; $display("FAIL sra_cc: got %b exp %b", o_CCodes, 4'b0010); end
        send(4'b1010, 32'h8000_0001, 32'h20, 1'b1);
        n_checks++; if (o_rslt !== 32'h8000_0001) begin n_fail++; $display("FAIL shr0_rslt: got %h exp %h", o_rslt, 32'h8000_0001); end
        n_checks++; if (o_CCodes !== 4'b0010) begin n_fail++; $display("FAIL shr0_cc: got %b exp %b", o_CCodes, 4'b0010); end
        send(4'b1001, 32'h8000_0001, 32'h1, 1'b1);
        n_checks++; if (o_rslt !== 32'h0000_0002) begin n_fail++; $display("FAIL shl_rslt: got %h exp %h", o_rslt, 32'h2); end
        n_checks++; if (o_CCodes !== 4'b0100) begin n_fail++; $display("FAIL shl_cc: got %b exp %b", o_CCodes, 4'b0100); end
        send(4'b1000, 32'h5, 32'h5, 1'b1);
        n_checks++; if (o_rslt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sbb_rslt: got %h exp %h", o_rslt, 32'hFFFF_FFFF); end
        n_checks++; if (o_CCodes !== 4'b0110) begin n_fail++; $display("FAIL sbb_cc: got %b exp %b", o_CCodes, 4'b0110); end
        send(4'b0011, 32'hF0, 32'h0F, 1'b0);
        n_checks++; if (o_rslt !== 32'hFF) begin n_fail++; $display("FAIL or_rslt: got %h exp %h", o_rslt, 32'hFF); end
        n_checks++; if (o_CCodes !== 4'b0110) begin n_fail++; $display("FAIL cc_hold: got %b exp %b", o_CCodes, 4'b0110); end
        send(4'b0101, 32'h0, 32'h0, 1'b0);
        n_checks++; if (o_rslt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL not_rslt: got %h exp %h", o_rslt, 32'hFFFF_FFFF); end
        send(4'b1111, 32'h1234, 32'h5678, 1'b1);
        n_checks++; if (o_rslt !== 32'h0) begin n_fail++; $display("FAIL unlisted_rslt: got %h exp %h", o_rslt, 32'h0); end
        n_checks++; if (o_CCodes !== 4'b0001) begin n_fail++; $display("FAIL unlisted_cc: got %b exp %b", o_CCodes, 4'b0001); end
    endtask

    task automatic test_mul();
        int  n;
        logic ready_bad;
        logic [31:0] a_tab [2];
        logic [31:0] b_tab [2];
        logic [31:0] r_tab [2];
        logic [3:0]  c_tab [2];
        a_tab[0] = 32'h0001_0000; b_tab[0] = 32'h0001_0000; r_tab[0] = 32'h0; c_tab[0] = 4'b1101;
        a_tab[1] = 32'h7;         b_tab[1] = 32'h6;         r_tab[1] = 32'd42; c_tab[1] = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            send(4'b1100, a_tab[k], b_tab[k], 1'b1);
            n = 0; ready_bad = 1'b0;
            while (!o_valid && n < 100) begin
                if (o_ready) ready_bad = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            n_checks++; if (n !== 32) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d edges exp %0d", k, n, 32); end
            n_checks++; if (ready_bad !== 1'b0) begin n_fail++; $display("FAIL mul_ready_low[%0d]: got %b exp %b", k, ready_bad, 1'b0); end
            n_checks++; if (o_rslt !== r_tab[k]) begin n_fail++; $display("FAIL mul_rslt[%0d]: got %h exp %h", k, o_rslt, r_tab[k]); end
            n_checks++; if (o_CCodes !== c_tab[k]) begin n_fail++; $display("FAIL mul_cc[%0d]: got %b exp %b", k, o_CCodes, c_tab[k]); end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        i_ready = 1'b0;
        send(4'b0001, 32'h1, 32'h2, 1'b0);
        n_checks++; if (o_rslt !== 32'h3) begin n_fail++; $display("FAIL bp_first: got %h exp %h", o_rslt, 32'h3); end
        i_ALU_Ctrl = 4'b0110; i_Op1 = 32'hF; i_Op2 = 32'h3; i_CC_WE = 1'b0; i_valid = 1'b1;
        #1;
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b exp %b", o_ready, 1'b0); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_rslt !== 32'h3 || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %h/%b exp %h/%b", o_rslt, o_valid, 32'h3, 1'b1); end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        n_checks++; if (o_rslt !== 32'hC || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second: got %h/%b exp %h/%b", o_rslt, o_valid, 32'hC, 1'b1); end
        @(posedge clk); #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b exp %b", o_valid, 1'b0); end
    endtask

    task automatic test_reset_mid_mul();
        logic saw_valid;
        send(4'b0000, 32'h0, 32'h0, 1'b1);
        send(4'b1100, 32'h0001_0000, 32'h0001_0000, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_valid: got %b exp %b", o_valid, 1'b0); end
        n_checks++; if (o_CCodes !== 4'b0000) begin n_fail++; $display("FAIL rstmul_cc: got %b exp %b", o_CCodes, 4'b0000); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_ready: got %b exp %b", o_ready, 1'b1); end
        saw_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_no_result: got %b exp %b", saw_valid, 1'b0); end
        send(4'b0001, 32'h2, 32'h3, 1'b1);
        n_checks++; if (o_rslt !== 32'h5 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmul_add: got %h/%b exp %h/%b", o_rslt, o_valid, 32'h5, 1'b1); end
        n_checks++; if (o_CCodes !== 4'b0000) begin n_fail++; $display("FAIL rstmul_add_cc: got %b exp %b", o_CCodes, 4'b0000); end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_back_to_back();
        test_flags_shifts();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
